// File: rtl/fe_pkg.sv
// Shared types and constants for the front-end memory bus: arbiter states, bus request
// record and default region bases.
package fe_pkg;

   typedef logic [31:0] RV32I_OPERAND_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ACCESS,
      ARB_ACK
   } arb_state_t;

   localparam logic [31:0] ROM_BASE_DEFAULT = 32'h0400_0000;
   localparam logic [31:0] RAM_BASE_DEFAULT = 32'h1001_0000;

   typedef struct packed {
      RV32I_OPERAND_t addr;
      logic           wren;
      RV32I_OPERAND_t wrdata;
   } bus_req_t;

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational decode of a byte address into ROM/RAM region hits, a word index and an
// error flag (misaligned, unmapped, or write to ROM).
module bus_addr_decoder
   import fe_pkg::*;
#(
   parameter logic [31:0] ROM_BASE  = ROM_BASE_DEFAULT,
   parameter logic [31:0] RAM_BASE  = RAM_BASE_DEFAULT,
   parameter int unsigned ROM_WORDS = 18,
   parameter int unsigned RAM_WORDS = 32
) (
   input  logic [31:0] addr,
   input  logic        wren,
   output logic        rom_hit,
   output logic        ram_hit,
   output logic        err,
   output logic [31:0] word_idx
);

   // Region ends carry an extra bit so a region touching the top of memory cannot wrap.
   localparam logic [32:0] RomEnd = {1'b0, ROM_BASE} + 33'(ROM_WORDS * 4);
   localparam logic [32:0] RamEnd = {1'b0, RAM_BASE} + 33'(RAM_WORDS * 4);

   always_comb begin
      rom_hit  = (addr >= ROM_BASE) && ({1'b0, addr} < RomEnd);
      ram_hit  = (addr >= RAM_BASE) && ({1'b0, addr} < RamEnd);
      word_idx = '0;
      if (rom_hit) begin
         word_idx = (addr - ROM_BASE) >> 2;
      end else if (ram_hit) begin
         word_idx = (addr - RAM_BASE) >> 2;
      end
      err = (addr[1:0] != 2'b00) || !(rom_hit || ram_hit) || (wren && rom_hit);
   end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter sharing the program ROM and data RAM; each granted
// transfer runs IDLE -> ACCESS (1+WAIT_STATES cycles, or 1 on error) -> ACK.
module bus_arbiter
   import fe_pkg::*;
#(
   parameter logic [31:0] ROM_BASE    = ROM_BASE_DEFAULT,
   parameter logic [31:0] RAM_BASE    = RAM_BASE_DEFAULT,
   parameter int unsigned ROM_WORDS   = 18,
   parameter int unsigned RAM_WORDS   = 32,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   input  logic        m0_wren,
   input  logic [31:0] m0_wrdata,
   output logic        m0_ack,
   output logic        m0_err,
   output logic [31:0] m0_rddata,
   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   input  logic        m1_wren,
   input  logic [31:0] m1_wrdata,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [31:0] m1_rddata,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_rddata,
   output logic [31:0] ram_addr,
   output logic        ram_wren,
   output logic [31:0] ram_wrdata,
   input  logic [31:0] rram_rddata
);

   localparam logic [3:0] WaitLast = 4'(WAIT_STATES);

   arb_state_t  state_q, state_d;
   logic        prio_q, prio_d;
   logic        gnt_q, gnt_d;
   logic [3:0]  wait_q, wait_d;
   bus_req_t    req_q, req_d;
   logic [31:0] rd0_q, rd0_d;
   logic [31:0] rd1_q, rd1_d;

   logic        rom_hit, ram_hit, dec_err;
   logic [31:0] word_idx;
   logic        in_access, last_access, in_ack;

   bus_addr_decoder #(
      .ROM_BASE  (ROM_BASE),
      .RAM_BASE  (RAM_BASE),
      .ROM_WORDS (ROM_WORDS),
      .RAM_WORDS (RAM_WORDS)
   ) u_decoder (
      .addr     (req_q.addr),
      .wren     (req_q.wren),
      .rom_hit  (rom_hit),
      .ram_hit  (ram_hit),
      .err      (dec_err),
      .word_idx (word_idx)
   );

   assign in_access   = (state_q == ARB_ACCESS);
   assign in_ack      = (state_q == ARB_ACK);
   assign last_access = in_access && (dec_err || (wait_q == WaitLast));

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      gnt_d   = gnt_q;
      wait_d  = wait_q;
      req_d   = req_q;
      rd0_d   = rd0_q;
      rd1_d   = rd1_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (m0_req || m1_req) begin
               gnt_d = (m0_req && m1_req) ? prio_q : m1_req;
               if (gnt_d) begin
                  req_d.addr   = m1_addr;
                  req_d.wren   = m1_wren;
                  req_d.wrdata = m1_wrdata;
               end else begin
                  req_d.addr   = m0_addr;
                  req_d.wren   = m0_wren;
                  req_d.wrdata = m0_wrdata;
               end
               wait_d  = '0;
               state_d = ARB_ACCESS;
            end
         end
         ARB_ACCESS: begin
            if (last_access) begin
               wait_d  = '0;
               state_d = ARB_ACK;
               // Writes carry no read data, so only mapped reads refresh rddata.
               if (!dec_err && !req_q.wren) begin
                  if (gnt_q) begin
                     rd1_d = rom_hit ? rom_rddata : rram_rddata;
                  end else begin
                     rd0_d = rom_hit ? rom_rddata : rram_rddata;
                  end
               end
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         ARB_ACK: begin
            prio_d  = ~gnt_q;
            state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ARB_IDLE;
         prio_q  <= 1'b0;
         gnt_q   <= 1'b0;
         wait_q  <= '0;
         req_q   <= '0;
         rd0_q   <= '0;
         rd1_q   <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         gnt_q   <= gnt_d;
         wait_q  <= wait_d;
         req_q   <= req_d;
         rd0_q   <= rd0_d;
         rd1_q   <= rd1_d;
      end
   end

   // Strobes are qualified by rst so a transfer caught by reset neither acks nor writes.
   assign m0_ack     = rst && in_ack && !gnt_q;
   assign m1_ack     = rst && in_ack && gnt_q;
   assign m0_err     = m0_ack && dec_err;
   assign m1_err     = m1_ack && dec_err;
   assign m0_rddata  = rd0_q;
   assign m1_rddata  = rd1_q;
   assign rom_addr   = (in_access && rom_hit) ? word_idx : '0;
   assign ram_addr   = (in_access && ram_hit) ? word_idx : '0;
   assign ram_wren   = rst && last_access && !dec_err && ram_hit && req_q.wren;
   assign ram_wrdata = req_q.wrdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: transaction-level reference model with per-cycle compare on a
// zero-wait instance, directed cases, random two-master traffic, and a 3-wait-state instance.
module tb_bus_arbiter;

   localparam logic [31:0] ROM_B = 32'h0400_0000;
   localparam logic [31:0] RAM_B = 32'h1001_0000;
   localparam int          ROM_W = 18;
   localparam int          RAM_W = 32;
   localparam int          WS    = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req   [2];
   logic [31:0] addr  [2];
   logic        wren  [2];
   logic [31:0] wdata [2];
   logic        ack   [2];
   logic        err   [2];
   logic [31:0] rdata [2];
   logic [31:0] rom_addr, rom_rddata, ram_addr, ram_wrdata, rram_rddata;
   logic        ram_wren;
   logic [31:0] env_ram [RAM_W];

   function automatic logic [31:0] rom_val(input logic [31:0] i);
      return 32'hA000_0000 | i;
   endfunction

   assign rom_rddata  = rom_val(rom_addr);
   assign rram_rddata = (ram_addr < RAM_W) ? env_ram[ram_addr[4:0]] : 32'h5A5A_5A5A;

   bus_arbiter #(.WAIT_STATES(WS)) dut (
      .clk(clk), .rst(rst),
      .m0_req(req[0]), .m0_addr(addr[0]), .m0_wren(wren[0]), .m0_wrdata(wdata[0]),
      .m0_ack(ack[0]), .m0_err(err[0]), .m0_rddata(rdata[0]),
      .m1_req(req[1]), .m1_addr(addr[1]), .m1_wren(wren[1]), .m1_wrdata(wdata[1]),
      .m1_ack(ack[1]), .m1_err(err[1]), .m1_rddata(rdata[1]),
      .rom_addr(rom_addr), .rom_rddata(rom_rddata),
      .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wrdata(ram_wrdata),
      .rram_rddata(rram_rddata)
   );

   // Second instance with wait states; master 1 idle.
   logic        w_rst, w_req, w_wren, w_ack, w_err, w_ram_wren, u_ack, u_err;
   logic [31:0] w_addr, w_wdata, w_rd, w_rom_addr, w_ram_addr, w_ram_wrdata, u_rd;

   bus_arbiter #(.WAIT_STATES(3)) dut_ws (
      .clk(clk), .rst(w_rst),
      .m0_req(w_req), .m0_addr(w_addr), .m0_wren(w_wren), .m0_wrdata(w_wdata),
      .m0_ack(w_ack), .m0_err(w_err), .m0_rddata(w_rd),
      .m1_req(1'b0), .m1_addr(32'h0), .m1_wren(1'b0), .m1_wrdata(32'h0),
      .m1_ack(u_ack), .m1_err(u_err), .m1_rddata(u_rd),
      .rom_addr(w_rom_addr), .rom_rddata(rom_val(w_rom_addr)),
      .ram_addr(w_ram_addr), .ram_wren(w_ram_wren), .ram_wrdata(w_ram_wrdata),
      .rram_rddata(32'hC0DE_0000 | w_ram_addr)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // ---------------- reference model: one transfer in flight, scheduled by cycle ----------
   bit          t_valid, t_gnt, t_ok, t_ram, t_wren, prio;
   int          t_first, t_last, t_ack, t_idx;
   logic [31:0] t_wdata;
   logic [31:0] exp_rd  [2];
   logic [31:0] mdl_ram [RAM_W];

   function automatic void decode(input logic [31:0] a, input logic w, output bit ok,
                                  output bit is_ram, output int idx);
      longint la, rb, mb;
      bit     in_rom, in_ram;
      la     = a;
      rb     = ROM_B;
      mb     = RAM_B;
      in_rom = (la >= rb) && (la < rb + 4 * ROM_W);
      in_ram = (la >= mb) && (la < mb + 4 * RAM_W);
      ok     = (la % 4 == 0) && (in_rom || in_ram) && !(w && in_rom);
      is_ram = in_ram;
      idx    = in_rom ? int'((la - rb) / 4) : (in_ram ? int'((la - mb) / 4) : 0);
   endfunction

   task automatic model_step();
      cyc++;
      if (!rst) begin
         t_valid   = 1'b0;
         prio      = 1'b0;
         exp_rd[0] = '0;
         exp_rd[1] = '0;
      end else begin
         if (t_valid && cyc == t_ack + 1) prio = !t_gnt;
         if (t_valid && t_ok && cyc == t_last + 1) begin
            if (t_ram && t_wren) mdl_ram[t_idx] = t_wdata;
            else if (!t_wren) exp_rd[t_gnt] = t_ram ? mdl_ram[t_idx] : rom_val(t_idx);
         end
         if ((!t_valid || cyc >= t_ack + 2) && (req[0] || req[1])) begin
            t_gnt = (req[0] && req[1]) ? prio : req[1];
            decode(addr[t_gnt], wren[t_gnt], t_ok, t_ram, t_idx);
            t_wren  = wren[t_gnt];
            t_wdata = wdata[t_gnt];
            t_valid = 1'b1;
            t_first = cyc;
            t_last  = cyc + (t_ok ? WS : 0);
            t_ack   = t_last + 1;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // ---------------- per-cycle compare ----------------
   bit          chk_en = 1'b0;
   int          ack_log[$];
   int          wren_cnt = 0;
   logic [31:0] last_wren_addr;

   task automatic compare_cycle();
      logic ea, ew, in_acc;
      for (int m = 0; m < 2; m++) begin
         ea = t_valid && cyc == t_ack && t_gnt == m;
         chk($sformatf("m%0d_ack", m), ack[m], ea);
         chk($sformatf("m%0d_err", m), err[m], ea && !t_ok);
         chk($sformatf("m%0d_rddata", m), rdata[m], exp_rd[m]);
         if (ack[m] === 1'b1) ack_log.push_back(m);
      end
      chk("single_ack", ack[0] && ack[1], 1'b0);
      ew = t_valid && t_ok && t_ram && t_wren && cyc == t_last;
      chk("ram_wren", ram_wren, ew);
      in_acc = t_valid && t_ok && cyc >= t_first && cyc <= t_last;
      if (in_acc && t_ram) chk("ram_addr", ram_addr, t_idx);
      if (in_acc && !t_ram) chk("rom_addr", rom_addr, t_idx);
      if (ew) chk("ram_wrdata", ram_wrdata, t_wdata);
      if (ram_wren === 1'b1) begin
         wren_cnt++;
         last_wren_addr = ram_addr;
         if (ram_addr < RAM_W) env_ram[ram_addr[4:0]] = ram_wrdata;
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (chk_en) compare_cycle();
   end

   int w_ack_cnt = 0;
   int w_wren_cnt = 0;
   initial forever begin
      @(negedge clk);
      if (w_ack === 1'b1) w_ack_cnt++;
      if (w_ram_wren === 1'b1) w_wren_cnt++;
   end

   // ---------------- master drivers ----------------
   task automatic run_xfer(input int m, input logic [31:0] a, input logic w,
                           input logic [31:0] d, output logic [31:0] rd, output logic er,
                           output int lat);
      @(posedge clk);
      #1;
      req[m] = 1'b1; addr[m] = a; wren[m] = w; wdata[m] = d;
      lat = 0;
      forever begin
         @(negedge clk);
         if (ack[m] === 1'b1) break;
         lat++;
         // Once latched, the master's bus lines must no longer matter.
         if (t_valid && t_gnt == m && cyc >= t_first && cyc < t_ack) begin
            addr[m] = $urandom; wdata[m] = $urandom; wren[m] = 1'($urandom_range(0, 1));
         end
         if (lat > 40) begin
            n_cmp++; n_bad++;
            $display("FAIL m%0d_timeout: got no ack expected ack within 40 cycles", m);
            break;
         end
      end
      rd = rdata[m];
      er = err[m];
   endtask

   task automatic drop(input int m);
      @(posedge clk);
      #1 req[m] = 1'b0;
   endtask

   function automatic logic [31:0] pick_addr();
      int s = $urandom_range(0, 11);
      case (s)
         0, 1, 2, 3: return ROM_B + 32'(4 * $urandom_range(0, ROM_W - 1));
         4, 5, 6, 7: return RAM_B + 32'(4 * $urandom_range(0, RAM_W - 1));
         8:          return ROM_B + 32'(4 * ROM_W);
         9:          return RAM_B - 32'd4;
         10:         return RAM_B + 32'(4 * $urandom_range(0, RAM_W - 1) + $urandom_range(1, 3));
         default:    return $urandom;
      endcase
   endfunction

   task automatic master_loop(input int m, input int n);
      logic [31:0] rd;
      logic        er;
      int          lat, gap;
      for (int k = 0; k < n; k++) begin
         gap = $urandom_range(0, 3);
         if (gap > 0) begin
            drop(m);
            repeat (gap - 1) @(posedge clk);
         end
         run_xfer(m, pick_addr(), 1'($urandom_range(0, 1)), $urandom, rd, er, lat);
      end
      drop(m);
   endtask

   task automatic ws_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat);
      @(posedge clk);
      #1 w_req = 1'b1; w_addr = a; w_wren = w; w_wdata = d;
      lat = 0;
      forever begin
         @(negedge clk);
         if (w_ack === 1'b1) break;
         lat++;
         if (lat > 40) begin
            n_cmp++; n_bad++;
            $display("FAIL ws_timeout: got no ack expected ack within 40 cycles");
            break;
         end
      end
      rd = w_rd;
      er = w_err;
      @(posedge clk);
      #1 w_req = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   logic [31:0] rd, rd_b, rd_before;
   logic        er, er_b;
   int          lat, lat_b, w0, a0;

   initial begin
      rst = 1'b0; w_rst = 1'b0; w_req = 1'b0; w_addr = '0; w_wren = 1'b0; w_wdata = '0;
      for (int m = 0; m < 2; m++) begin
         req[m] = 1'b0; addr[m] = '0; wren[m] = 1'b0; wdata[m] = '0;
      end
      for (int i = 0; i < RAM_W; i++) begin
         env_ram[i] = '0;
         mdl_ram[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_m0_ack", ack[0], 1'b0);
      chk("rst_m1_rddata", rdata[1], 32'h0);
      chk("rst_ram_wren", ram_wren, 1'b0);
      chk("rst_rom_addr", rom_addr, 32'h0);
      chk("rst_ram_wrdata", ram_wrdata, 32'h0);

      // ROM read, zero wait states
      run_xfer(0, 32'h0400_0008, 1'b0, 32'h0, rd, er, lat);
      chk("t1_lat", lat, 2);
      chk("t1_rd", rd, 32'hA000_0002);
      chk("t1_err", er, 1'b0);
      chk("t1_mdl_idx", t_idx, 2);
      drop(0);

      // RAM write then read-back from master 1
      w0 = wren_cnt;
      run_xfer(1, 32'h1001_0010, 1'b1, 32'hDEAD_BEEF, rd, er, lat);
      chk("t2_wren_pulses", wren_cnt - w0, 1);
      chk("t2_wren_addr", last_wren_addr, 32'd4);
      chk("t2_werr", er, 1'b0);
      run_xfer(1, 32'h1001_0010, 1'b0, 32'h0, rd, er, lat);
      chk("t2_rd", rd, 32'hDEAD_BEEF);
      chk("t2_lat", lat, 2);
      drop(1);

      // Both masters held: strict alternation starting with m0
      ack_log.delete();
      fork
         begin
            run_xfer(0, ROM_B + 32'd4, 1'b0, 32'h0, rd, er, lat);
            run_xfer(0, ROM_B + 32'd68, 1'b0, 32'h0, rd, er, lat);
            drop(0);
         end
         begin
            run_xfer(1, RAM_B + 32'h10, 1'b0, 32'h0, rd_b, er_b, lat_b);
            run_xfer(1, RAM_B + 32'h7C, 1'b0, 32'h0, rd_b, er_b, lat_b);
            drop(1);
         end
      join
      chk("t3_rd_m0", rd, 32'hA000_0011);
      chk("t3_n_acks", ack_log.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < ack_log.size()) chk($sformatf("t3_order%0d", i), ack_log[i], i % 2);
      end

      // Error transfers
      w0 = wren_cnt;
      rd_before = rdata[0];
      run_xfer(0, 32'h0000_0000, 1'b0, 32'h0, rd, er, lat);
      chk("t4_unmapped_err", er, 1'b1);
      chk("t4_unmapped_rd", rd, rd_before);
      run_xfer(0, 32'h1001_0002, 1'b0, 32'h0, rd, er, lat);
      chk("t4_misaligned_err", er, 1'b1);
      chk("t4_err_lat", lat, 2);
      run_xfer(0, 32'h0400_0000, 1'b1, 32'h1234_5678, rd, er, lat);
      chk("t4_romwrite_err", er, 1'b1);
      chk("t4_romwrite_rd", rd, rd_before);
      chk("t4_no_wren", wren_cnt - w0, 0);
      drop(0);

      // Random two-master traffic
      fork
         master_loop(0, 60);
         master_loop(1, 60);
      join
      repeat (4) @(posedge clk);
      chk_en = 1'b0;

      // Wait-state instance: latency, then reset mid-ACCESS
      @(posedge clk);
      #1 w_rst = 1'b1;
      ws_xfer(RAM_B + 32'h14, 1'b0, 32'h0, rd, er, lat);
      chk("t5_lat", lat, 5);
      chk("t5_rd", rd, 32'hC0DE_0005);
      chk("t5_err", er, 1'b0);
      a0 = w_ack_cnt;
      w0 = w_wren_cnt;
      @(posedge clk);
      #1 w_req = 1'b1; w_addr = RAM_B; w_wren = 1'b1; w_wdata = 32'hFEED_F00D;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 w_rst = 1'b0; w_req = 1'b0;
      @(posedge clk);
      #1 w_rst = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("t5_abort_no_ack", w_ack_cnt - a0, 0);
      chk("t5_abort_no_wren", w_wren_cnt - w0, 0);
      chk("t5_rst_rd", w_rd, 32'h0);
      ws_xfer(RAM_B, 1'b0, 32'h0, rd, er, lat);
      chk("t5_idle_lat", lat, 5);
      chk("t5_idle_rd", rd, 32'hC0DE_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
